// File: rtl/mod_generate_demux_pkg.sv
// Shared types and constants for the steering demux.
// Optional stats build: MOD_GENERATE_DEMUX_STATS_EN.
package mod_generate_demux_pkg;

  typedef enum logic {
    LANE_A = 1'b0,
    LANE_B = 1'b1
  } lane_e;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  function automatic logic [COUNT_W-1:0] sat_inc(
    input logic [COUNT_W-1:0] v
  );
    return (v == COUNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mod_generate_demux_lane.sv
// Per-lane FIFO: registered head, no fall-through,
// pop while empty ignored, data reads 0 when empty.
module mod_generate_demux_lane
  import mod_generate_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;

  assign o_valid = (r_cnt != '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = i_ready && o_valid;
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;

  // storage write at the write pointer
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  // pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mod_generate_demux.sv
// One input stream steered to lane A or B by i_sel.
// Stats counters: define MOD_GENERATE_DEMUX_STATS_EN.
module mod_generate_demux
  import mod_generate_demux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DUAL_LANE = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_sel,
  input  logic [WIDTH-1:0]   i_data,
  output logic               o_ready,
  output logic               o_a_valid,
  output logic [WIDTH-1:0]   o_a_data,
  input  logic               i_a_ready,
  output logic               o_b_valid,
  output logic [WIDTH-1:0]   o_b_data,
  input  logic               i_b_ready,
  output logic [COUNT_W-1:0] o_count_a,
  output logic [COUNT_W-1:0] o_count_b
);

  lane_e w_sel;
  logic  w_a_full;
  logic  w_b_full;
  logic  w_push_a;
  logic  w_push_b;

  assign w_sel = (DUAL_LANE != 0) ? lane_e'(i_sel)
                                  : LANE_A;

  assign o_ready = !i_rst &&
                   ((w_sel == LANE_B) ? !w_b_full
                                      : !w_a_full);

  assign w_push_a = i_valid && o_ready &&
                    (w_sel == LANE_A);
  assign w_push_b = i_valid && o_ready &&
                    (w_sel == LANE_B);

  mod_generate_demux_lane #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push_a),
    .i_data  (i_data),
    .i_ready (i_a_ready),
    .o_full  (w_a_full),
    .o_valid (o_a_valid),
    .o_data  (o_a_data)
  );

  if (DUAL_LANE != 0) begin : gen_dual
    mod_generate_demux_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_lane_b (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push_b),
      .i_data  (i_data),
      .i_ready (i_b_ready),
      .o_full  (w_b_full),
      .o_valid (o_b_valid),
      .o_data  (o_b_data)
    );
  end else begin : gen_single
    logic w_unused_b_ready;
    assign w_unused_b_ready = i_b_ready;
    assign w_b_full  = 1'b0;
    assign o_b_valid = 1'b0;
    assign o_b_data  = '0;
  end

`ifdef MOD_GENERATE_DEMUX_STATS_EN
  logic [COUNT_W-1:0] r_count_a;
  logic [COUNT_W-1:0] r_count_b;

  // saturating per-lane accept counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count_a <= '0;
      r_count_b <= '0;
    end else begin
      if (w_push_a) r_count_a <= sat_inc(r_count_a);
      if (w_push_b) r_count_b <= sat_inc(r_count_b);
    end
  end

  assign o_count_a = r_count_a;
  assign o_count_b = r_count_b;
`else
  assign o_count_a = '0;
  assign o_count_b = '0;
`endif

endmodule

// File: tb/tb_mod_generate_demux.sv
// Queue-model bench for mod_generate_demux,
// dual-lane and single-lane builds side by side.
module tb_mod_generate_demux;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         valid;
  logic         sel;
  logic [W-1:0] data;
  logic         a_rdy;
  logic         b_rdy;

  logic         d_ready, d_a_valid, d_b_valid;
  logic [W-1:0] d_a_data, d_b_data;
  logic [15:0]  d_count_a, d_count_b;

  logic         s_ready, s_a_valid, s_b_valid;
  logic [W-1:0] s_a_data, s_b_data;
  logic [15:0]  s_count_a, s_count_b;

  mod_generate_demux #(
    .WIDTH(W), .DEPTH(D), .DUAL_LANE(1)
  ) u_dual (
    .i_clk(clk), .i_rst(rst),
    .i_valid(valid), .i_sel(sel), .i_data(data),
    .o_ready(d_ready),
    .o_a_valid(d_a_valid), .o_a_data(d_a_data),
    .i_a_ready(a_rdy),
    .o_b_valid(d_b_valid), .o_b_data(d_b_data),
    .i_b_ready(b_rdy),
    .o_count_a(d_count_a), .o_count_b(d_count_b)
  );

  mod_generate_demux #(
    .WIDTH(W), .DEPTH(D), .DUAL_LANE(0)
  ) u_single (
    .i_clk(clk), .i_rst(rst),
    .i_valid(valid), .i_sel(sel), .i_data(data),
    .o_ready(s_ready),
    .o_a_valid(s_a_valid), .o_a_data(s_a_data),
    .i_a_ready(a_rdy),
    .o_b_valid(s_b_valid), .o_b_data(s_b_data),
    .i_b_ready(b_rdy),
    .o_count_a(s_count_a), .o_count_b(s_count_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] qs[$];
  int ca = 0, cb = 0, cs = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic step(input bit r, input bit v,
                      input bit s, input logic [W-1:0] dt,
                      input bit ar, input bit br,
                      output bit acc);
    bit e_rdy, s_rdy, pa, pb, ps, s_acc;
    @(negedge clk);
    rst = r; valid = v; sel = s; data = dt;
    a_rdy = ar; b_rdy = br;
    #1;
    e_rdy = !r && (s ? (qb.size() < D) : (qa.size() < D));
    s_rdy = !r && (qs.size() < D);
    check("d_ready", d_ready, e_rdy);
    check("d_a_valid", d_a_valid, qa.size() != 0);
    if (qa.size() != 0) check("d_a_data", d_a_data, qa[0]);
    check("d_b_valid", d_b_valid, qb.size() != 0);
    if (qb.size() != 0) check("d_b_data", d_b_data, qb[0]);
    check("s_ready", s_ready, s_rdy);
    check("s_a_valid", s_a_valid, qs.size() != 0);
    if (qs.size() != 0) check("s_a_data", s_a_data, qs[0]);
    check("s_b_valid", s_b_valid, 0);
    check("s_b_data", s_b_data, 0);
    check("s_count_b", s_count_b, 0);
`ifdef MOD_GENERATE_DEMUX_STATS_EN
    check("d_count_a", d_count_a, ca);
    check("d_count_b", d_count_b, cb);
    check("s_count_a", s_count_a, cs);
`else
    check("d_count_a", d_count_a, 0);
    check("d_count_b", d_count_b, 0);
    check("s_count_a", s_count_a, 0);
`endif
    acc   = v && e_rdy;
    s_acc = v && s_rdy;
    if (r) begin
      qa.delete(); qb.delete(); qs.delete();
      ca = 0; cb = 0; cs = 0;
    end else begin
      pa = (qa.size() != 0) && ar;
      pb = (qb.size() != 0) && br;
      ps = (qs.size() != 0) && ar;
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (ps) void'(qs.pop_front());
      if (acc) begin
        if (s) begin qb.push_back(dt); cb = sat(cb); end
        else   begin qa.push_back(dt); ca = sat(ca); end
      end
      if (s_acc) begin qs.push_back(dt); cs = sat(cs); end
    end
  endtask

  bit acc;
  int n;

  initial begin
    rst = 1'b1; valid = 1'b0; sel = 1'b0;
    data = '0; a_rdy = 1'b0; b_rdy = 1'b0;
    repeat (2) @(posedge clk);

    // reset release and idle
    step(0, 0, 0, 8'h00, 0, 0, acc);
    step(0, 0, 1, 8'h00, 0, 0, acc);
    // ready low during reset
    step(1, 1, 0, 8'h77, 1, 1, acc);
    step(0, 0, 0, 8'h00, 1, 1, acc);

    // steering
    step(0, 1, 0, 8'h11, 1, 1, acc);
    step(0, 1, 1, 8'h22, 1, 1, acc);
    step(0, 0, 0, 8'h00, 1, 1, acc);
    step(0, 0, 0, 8'h00, 1, 1, acc);

    // fill lane A
    for (int i = 0; i < D; i++)
      step(0, 1, 0, 8'hA0 + 8'(i), 0, 1, acc);
    step(0, 1, 0, 8'hEE, 0, 1, acc);
    step(0, 1, 1, 8'h33, 0, 1, acc);
    step(0, 1, 0, 8'hEF, 1, 1, acc);
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 8'h00, 1, 1, acc);

    // wrap-around with toggling ready
    n = 0;
    for (int k = 0; k < 40 && n < 10; k++) begin
      step(0, 1, 0, n[7:0], k[0], 1, acc);
      if (acc) n++;
    end
    check("wrap_sent", n, 10);
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 8'h00, 1, 1, acc);

    // reset with beats parked in B
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 8'hB0 + 8'(i), 1, 0, acc);
    step(1, 0, 0, 8'h00, 0, 0, acc);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 8'h00, 1, 1, acc);

    // sel=1 into single-lane build
    step(0, 1, 1, 8'h5A, 0, 0, acc);
    step(0, 0, 0, 8'h00, 1, 1, acc);
    step(0, 0, 0, 8'h00, 1, 1, acc);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 7,
           1'($urandom),
           8'($urandom),
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 6,
           acc);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
